uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
- Serial transmit end of the byte-stream interface that the SDRAM/UART top level exposes as tx_dat/tx_stb/tx_ack.
- Accepts bytes from the stream source over the stb/ack handshake and buffers one byte in a holding register.
- Serializes each byte onto an asynchronous UART line as start bit, data LSB first, optional parity, and stop bit(s).
- Sits between all_modules' tx port and the board TXD pin.

Parameters:
- CLKS_PER_BIT, 1155, clock cycles per bit (133 MHz / 115200 baud, rounded); legal range 2..65535.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- CLK_133MHZ  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- tx_dat  in  8  byte from the stream source; must be stable while tx_stb is high.
- tx_stb  in  1  source has a valid byte.
- tx_ack  out  1  one-cycle pulse: byte captured.
- txd  out  1  serial line; idle high.
- busy  out  1  high while a frame is on the line or the holding register is full.

Behaviour:
- Reset values (rst low at a rising edge): txd=1, tx_ack=0, busy=0, hold_valid=0, state=IDLE, all counters 0. Any frame in progress is abandoned; the line returns high on that edge.
- Handshake:
  - Capture happens at an edge where tx_stb=1, hold_valid=0 and tx_ack=0. At that edge hold_reg<=tx_dat, hold_valid<=1, tx_ack<=1.
  - tx_ack is high for exactly one cycle. It is never high in two consecutive cycles.
  - tx_stb is ignored in any cycle where tx_ack=1. The source therefore drops tx_stb, or presents the next byte, on the edge where it sees tx_ack without causing a double capture.
  - While hold_valid=1, tx_stb is stalled (no ack).
- Registers: a baud counter (16 bit) counts 0..CLKS_PER_BIT-1. A bit index counts 0..7 in DATA and 0..STOP_BITS-1 in STOP.
- State machine:
  - IDLE: txd=1. If hold_valid, then shift<=hold_reg, parity accumulator<=(PARITY==1), hold_valid<=0, go to START, baud counter<=0.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles. At the end of each bit: shift right, XOR the bit into the parity accumulator, increment the bit index. After bit 7, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: txd=accumulator for CLKS_PER_BIT cycles. With odd parity the total ones count including the parity bit is odd; with even parity it is even. Then go to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end, if hold_valid, load the next byte and go directly to START with no idle cycle; else go to IDLE.
- Latency: tx_stb sampled at edge N (line idle, holding register empty) gives tx_ack high after N and txd low after N+1.
- Buffering: the holding register refills while a frame shifts. A second byte is acked during the first frame, so a continuous source sees gap-free frames.
- Simultaneous events:
  - When a frame ends at the same edge as a capture, the captured byte is not visible to the STOP→START decision until the next edge. That byte goes via IDLE, giving one idle cycle.
  - Capture and the hold→shift transfer never coincide, because the transfer requires hold_valid=1 and capture requires hold_valid=0.
- busy = (state!=IDLE) | hold_valid, registered.
- txd is driven straight from a flop (glitch-free).

Test Plan:
- Reset and idle: hold rst low 3 cycles, tx_stb=0 → txd=1, tx_ack=0, busy=0. Keep tx_stb=0 for 100 cycles → outputs unchanged.
- Single byte, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1: tx_dat=0x53 pulsed with stb/ack → tx_ack one cycle after stb, txd low 2 cycles after stb. The line shows 0,1,1,0,0,1,0,1,0,1, each held 4 cycles (40 cycles total), then idle with busy=0.
- Parity: 0x53 with PARITY=2 → parity bit 0. With PARITY=1 → parity bit 1. Frame is 44 cycles. STOP_BITS=2 → stop high for 8 cycles.
- Back-to-back: source drives 0x53..0x57 exactly as a held stb dropped after ack → second ack arrives during the first frame; five frames with no idle between them (200 cycles); no byte duplicated or lost.
- Stall: stb held high with a new byte while the holding register is full → no tx_ack until the current frame's stop bit completes. tx_ack is never high 2 consecutive cycles.
- Reset mid-frame: assert rst during data bit 3 → txd=1 and busy=0 on the next edge, pending hold byte discarded. After release, a new byte 0xA5 transmits correctly.

Source files
------------

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a stb/ack byte stream, with a one-byte holding register
// so a continuous source produces back-to-back frames with no idle gap.
module uart_tx_stream #(
    parameter int CLKS_PER_BIT = 1155,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       CLK_133MHZ,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_ack,
    output logic       txd,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_INIT  = (PARITY == 1);

    state_t      state;
    logic [7:0]  hold_reg;
    logic        hold_valid;
    logic [7:0]  shift;
    logic        par_acc;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic        capture;
    logic        baud_end;

    // The ack cycle masks stb so a source reacting to ack cannot be captured twice.
    assign capture  = tx_stb & ~hold_valid & ~tx_ack;
    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK_133MHZ) begin
        if (!rst) begin
            state      <= IDLE;
            hold_reg   <= '0;
            hold_valid <= 1'b0;
            shift      <= '0;
            par_acc    <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx_ack     <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
        end else begin
            tx_ack <= capture;
            if (capture) begin
                hold_reg   <= tx_dat;
                hold_valid <= 1'b1;
                busy       <= 1'b1;
            end

            // txd is loaded with the level of the state being entered, so it is a pure flop.
            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (hold_valid) begin
                        shift      <= hold_reg;
                        par_acc    <= PAR_INIT;
                        hold_valid <= 1'b0;
                        baud_cnt   <= '0;
                        state      <= START;
                        txd        <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        txd      <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        par_acc  <= par_acc ^ shift[0];
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state <= PAR;
                                txd   <= par_acc ^ shift[0];
                            end else begin
                                state   <= STOP;
                                bit_idx <= '0;
                                txd     <= 1'b1;
                            end
                        end else begin
                            txd <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                PAR: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= STOP;
                        txd      <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            if (hold_valid) begin
                                shift      <= hold_reg;
                                par_acc    <= PAR_INIT;
                                hold_valid <= 1'b0;
                                state      <= START;
                                txd        <= 1'b0;
                            end else begin
                                // A byte captured on this very edge keeps busy up and goes out via IDLE.
                                state <= IDLE;
                                busy  <= capture;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Scoreboarded bench: three transmitters (no parity, even, odd/2 stop) at 4 clocks per bit;
// per-line monitors decode frames cycle-exactly and compare against queued expected frames.
module tb_uart_tx_stream;

    typedef struct {
        int          k;
        logic [11:0] bits;
        int          gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] dat_w [3];
    logic       stb_w [3];
    logic       ack_w [3];
    logic       txd_w [3];
    logic       busy_w [3];

    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;
    bit   mon_en     = 1'b0;
    int   nb [3]     = '{10, 11, 12};
    int   last_end [3];
    logic prev_ack [3];
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .CLK_133MHZ(clk), .rst(rst), .tx_dat(dat_w[0]), .tx_stb(stb_w[0]),
        .tx_ack(ack_w[0]), .txd(txd_w[0]), .busy(busy_w[0]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u1 (
        .CLK_133MHZ(clk), .rst(rst), .tx_dat(dat_w[1]), .tx_stb(stb_w[1]),
        .tx_ack(ack_w[1]), .txd(txd_w[1]), .busy(busy_w[1]));
    uart_tx_stream #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u2 (
        .CLK_133MHZ(clk), .rst(rst), .tx_dat(dat_w[2]), .tx_stb(stb_w[2]),
        .tx_ack(ack_w[2]), .txd(txd_w[2]), .busy(busy_w[2]));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Decode frames on line k, one sample per clock, and score them.
    task automatic monitor(input int k);
        exp_t        e;
        logic [11:0] got;
        logic        stable;
        int          st;
        bit          abort;
        forever begin
            @(negedge clk);
            if (!mon_en || !rst || txd_w[k] !== 1'b0) continue;
            st = cyc; got = '0; stable = 1'b1; abort = 1'b0;
            for (int b = 0; b < nb[k] && !abort; b++) begin
                for (int c = 0; c < 4 && !abort; c++) begin
                    if (!(b == 0 && c == 0)) @(negedge clk);
                    if (!rst) abort = 1'b1;
                    else if (c == 0) got[b] = txd_w[k];
                    else if (txd_w[k] !== got[b]) stable = 1'b0;
                end
            end
            if (abort) continue;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_frame: line %0d got %0h expected none", k, got);
            end else begin
                e = sb.pop_front();
                chk("frame_line", k, e.k);
                chk("frame_bits", {20'd0, got}, {20'd0, e.bits});
                chk("bit_stable", {31'd0, stable}, 32'd1);
                if (e.gap == 0) chk("gapless", st, last_end[k]);
            end
            last_end[k] = st + nb[k] * 4;
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    // tx_ack must never be high in two consecutive cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mon_en && ack_w[k] === 1'b1) chk("ack_single", {31'd0, prev_ack[k]}, 32'd0);
            prev_ack[k] = ack_w[k];
        end
    end

    task automatic send(input int k, input logic [7:0] b, output int waited);
        dat_w[k] = b;
        stb_w[k] = 1'b1;
        waited = 0;
        while (waited < 500) begin
            @(posedge clk); #1;
            waited++;
            if (ack_w[k] === 1'b1) break;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int bad;
        int exp_w [5] = '{1, 2, 40, 40, 40};
        for (int k = 0; k < 3; k++) begin
            dat_w[k] = 8'h00;
            stb_w[k] = 1'b0;
            prev_ack[k] = 1'b0;
            last_end[k] = 0;
        end

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("reset_txd", {31'd0, txd_w[k]}, 32'd1);
            chk("reset_ack", {31'd0, ack_w[k]}, 32'd0);
            chk("reset_busy", {31'd0, busy_w[k]}, 32'd0);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        bad = 0;
        repeat (100) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++)
                if (txd_w[k] !== 1'b1 || ack_w[k] !== 1'b0 || busy_w[k] !== 1'b0) bad++;
        end
        chk("idle_stable", bad, 0);

        // Single byte, no parity: latency and frame length
        sb.push_back('{0, 12'h2A6, -1});
        send(0, 8'h53, w);
        chk("ack_latency", w, 1);
        chk("txd_before_start", {31'd0, txd_w[0]}, 32'd1);
        stb_w[0] = 1'b0;
        @(posedge clk); #1;
        chk("start_latency", {31'd0, txd_w[0]}, 32'd0);
        repeat (39) @(posedge clk);
        #1;
        chk("busy_in_stop", {31'd0, busy_w[0]}, 32'd1);
        chk("txd_in_stop", {31'd0, txd_w[0]}, 32'd1);
        @(posedge clk); #1;
        chk("busy_after_frame", {31'd0, busy_w[0]}, 32'd0);
        drain();

        // Even parity (1 stop) and odd parity (2 stops), two bytes each
        sb.push_back('{1, 12'h4A6, -1});
        sb.push_back('{1, 12'h400, 0});
        send(1, 8'h53, w);
        send(1, 8'h00, w);
        chk("second_ack_in_frame", w, 2);
        stb_w[1] = 1'b0;
        drain();
        chk("busy_after_even", {31'd0, busy_w[1]}, 32'd0);
        sb.push_back('{2, 12'hEA6, -1});
        sb.push_back('{2, 12'hC02, 0});
        send(2, 8'h53, w);
        send(2, 8'h01, w);
        chk("second_ack_in_frame", w, 2);
        stb_w[2] = 1'b0;
        drain();
        chk("busy_after_odd", {31'd0, busy_w[2]}, 32'd0);

        // Back-to-back stream with stalls while the holding register is full
        sb.push_back('{0, 12'h2A6, -1});
        sb.push_back('{0, 12'h2A8, 0});
        sb.push_back('{0, 12'h2AA, 0});
        sb.push_back('{0, 12'h2AC, 0});
        sb.push_back('{0, 12'h2AE, 0});
        for (int i = 0; i < 5; i++) begin
            send(0, 8'h53 + 8'(i), w);
            chk("stream_ack_wait", w, exp_w[i]);
        end
        stb_w[0] = 1'b0;
        drain();
        chk("busy_after_stream", {31'd0, busy_w[0]}, 32'd0);

        // Reset during data bit 3 with a byte pending
        send(0, 8'h53, w);
        send(0, 8'h54, w);
        stb_w[0] = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("pre_reset_bit3", {31'd0, txd_w[0]}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midreset_txd", {31'd0, txd_w[0]}, 32'd1);
        chk("midreset_busy", {31'd0, busy_w[0]}, 32'd0);
        rst = 1'b1;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad++;
        end
        chk("hold_discarded", bad, 0);
        sb.push_back('{0, 12'h34A, -1});
        send(0, 8'hA5, w);
        chk("post_reset_ack", w, 1);
        stb_w[0] = 1'b0;
        drain();
        chk("busy_after_a5", {31'd0, busy_w[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
